kgp_add_scheduler: RTL
======================

KGP_ADD_SCHEDULER -- requirements
Module: kgp_add_scheduler

Interface
REQ-001 SHALL have parameter NBYTES, default 4, giving operand width in bytes (legal 1..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req0_valid, input, 1, requester 0 has an operand pair pending.
REQ-005 SHALL have port req0_ready, output, 1, requester 0 is granted this cycle.
REQ-006 SHALL have ports req0_a and req0_b, input, 8*NBYTES, requester 0 operands.
REQ-007 SHALL have port req0_cin, input, 1, requester 0 carry-in.
REQ-008 SHALL have ports req1_valid, req1_ready, req1_a, req1_b and req1_cin, identical in width and meaning to REQ-004..REQ-007, for requester 1.
REQ-009 SHALL have port rsp_valid, output, 1, a result is presented.
REQ-010 SHALL have port rsp_ready, input, 1, the consumer accepts the result.
REQ-011 SHALL have port rsp_id, output, 1, the requester that owns the result.
REQ-012 SHALL have port rsp_sum, output, 8*NBYTES+1, the result, with the final carry in the MSB.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL implement the states IDLE, ADD and DONE.
REQ-015 IDLE SHALL drive reqX_ready=1 combinationally for exactly one granted requester and 0 for the other.
- Grant rule: grant the only valid requester.
- If both are valid, grant the requester not served last (round-robin via a last_grant flag).
- If neither is valid, assert no ready.
REQ-016 Acceptance (valid&ready at a rising edge) SHALL:
- capture a, b and cin of the granted requester;
- record that requester as rsp_id and update last_grant;
- clear the byte index;
- move to ADD.
REQ-017 ADD SHALL process one byte per cycle, LSB byte first, through a single shared 8-bit adder.
- The adder takes byte i of a and b plus the carry register and returns a 9-bit result.
- Low 8 bits go to byte i of rsp_sum; bit 8 goes to the carry register.
- The carry register is loaded with cin at acceptance.
REQ-018 On the ADD cycle with index NBYTES-1, the block SHALL write the final carry to rsp_sum[8*NBYTES] and enter DONE.
- rsp_valid therefore rises exactly NBYTES cycles after the accepting edge.
REQ-019 DONE SHALL hold rsp_valid=1 with rsp_sum and rsp_id stable until a rising edge with rsp_ready=1, then return to IDLE.
REQ-020 No new request SHALL be accepted while busy; req0_ready and req1_ready SHALL both be 0 in ADD and DONE.
REQ-021 A request SHALL NOT be accepted on the same edge that DONE completes; the earliest next acceptance is the following cycle.
- Minimum spacing between acceptances is NBYTES+2 cycles.
REQ-022 Arithmetic SHALL be unsigned modulo 2^(8*NBYTES+1), with no overflow flag.
REQ-023 Requester operand inputs SHALL be ignored after acceptance; changes to them SHALL NOT affect an in-flight sum.
REQ-024 rsp_sum and rsp_id SHALL retain their last value in IDLE.

Reset
REQ-025 While rst_n=0, regardless of clk, the block SHALL hold:
- state=IDLE, rsp_valid=0, busy=0, rsp_sum=0, rsp_id=0;
- carry register=0 and byte index=0;
- last_grant=1, so requester 0 wins the first contention.
REQ-026 Reset asserted mid-ADD or mid-DONE SHALL discard the in-flight operation; no response for it SHALL ever appear.
REQ-027 After rst_n deasserts, the first acceptance SHALL be possible at the first rising edge.

Verification (NBYTES=4)
REQ-028 Scenario basic: req0 a=0x000000FF, b=0x00000001, cin=0 -> rsp_sum=0x0_00000100, rsp_id=0, rsp_valid 4 cycles after accept.
REQ-029 Scenario full ripple: req1 a=0xFFFFFFFF, b=0x00000000, cin=1 -> rsp_sum=0x1_00000000, rsp_id=1.
REQ-030 Scenario contention: both valid continuously with rsp_ready=1 -> rsp_id sequence 0,1,0,1 and acceptances exactly 6 cycles apart.
REQ-031 Scenario backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_sum and rsp_id stable, both readies 0, busy=1; release -> IDLE on the next cycle.
REQ-032 Scenario reset mid-op: rst_n pulsed low during ADD byte 2 -> outputs reset immediately with no response emitted; both requesters then valid -> req0 granted first.
REQ-033 Scenario operand change: req0_a modified the cycle after acceptance -> result reflects the captured value.

Source files
------------

// File: rtl/kgp_add_scheduler.sv
// kgp_add_scheduler: two-requester round-robin adder using one shared 8-bit adder, one byte per cycle
module kgp_add_scheduler #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [8*NBYTES-1:0] req0_a,
  input  logic [8*NBYTES-1:0] req0_b,
  input  logic                req0_cin,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [8*NBYTES-1:0] req1_a,
  input  logic [8*NBYTES-1:0] req1_b,
  input  logic                req1_cin,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [8*NBYTES:0]   rsp_sum,
  output logic                busy
);
  localparam int W = 8 * NBYTES;
  localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
  localparam logic [1:0] IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [W-1:0] a_q, b_q;
  logic carry;
  logic [IW-1:0] idx;
  logic [IW+2:0] bit_pos;
  logic last_grant;
  logic [8:0] sum9;
  assign bit_pos = {idx, 3'b000};
  assign sum9 = {1'b0, a_q[bit_pos +: 8]} + {1'b0, b_q[bit_pos +: 8]} + {8'd0, carry};
  assign rsp_valid = state == DONE;
  assign busy = state != IDLE;
  // grant in IDLE only; on contention the requester not served last wins
  always_comb begin
    req0_ready = state == IDLE && req0_valid && (!req1_valid || last_grant);
    req1_ready = state == IDLE && req1_valid && (!req0_valid || !last_grant);
  end
  // capture on grant, ripple one byte per cycle, hold result until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      carry      <= 1'b0;
      idx        <= '0;
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
    end else begin
      case (state)
        IDLE: if (req0_ready || req1_ready) begin
          a_q        <= req0_ready ? req0_a : req1_a;
          b_q        <= req0_ready ? req0_b : req1_b;
          carry      <= req0_ready ? req0_cin : req1_cin;
          rsp_id     <= req1_ready;
          last_grant <= req1_ready;
          idx        <= '0;
          state      <= ADD;
        end
        ADD: begin
          rsp_sum[bit_pos +: 8] <= sum9[7:0];
          carry <= sum9[8];
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            rsp_sum[W] <= sum9[8];
            state      <= DONE;
          end
        end
        DONE: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
